// File: rtl/generic_cntr_regs_pkg.sv
// Shared types for the generic counter register block: ring access classification.
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif

package generic_cntr_regs_pkg;

  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } acc_e;

  // Requests already acked upstream are never claimed, even if they address this block.
  function automatic acc_e classify(input logic req, input logic ack, input logic rd_wr_l,
                                    input logic tag_ok, input logic in_range);
    if (!req || ack || !tag_ok || !in_range) return ACC_NONE;
    return rd_wr_l ? ACC_READ : ACC_WRITE;
  endfunction

endpackage

// File: rtl/generic_cntr_regs_cell.sv
// One event counter: adds a per-cycle increment, with optional load, clear and saturation.
module generic_cntr_cell #(
  parameter int REG_WIDTH   = 32,
  parameter int INPUT_WIDTH = 1,
  parameter int SATURATE    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INPUT_WIDTH-1:0] inc,
  input  logic                   load,
  input  logic [REG_WIDTH-1:0]   load_val,
  input  logic                   clear_to_inc,
  output logic [REG_WIDTH-1:0]   value
);

  localparam int SW = REG_WIDTH + 1;

  logic [REG_WIDTH-1:0] value_q, value_d;
  logic [REG_WIDTH-1:0] base;
  logic [REG_WIDTH:0]   sum;

  // The increment is always added, so a load or clear in the same cycle never loses an event.
  always_comb begin
    base = value_q;
    if (load) begin
      base = load_val;
    end else if (clear_to_inc) begin
      base = '0;
    end
    sum     = {1'b0, base} + SW'(inc);
    value_d = sum[REG_WIDTH-1:0];
    if ((SATURATE != 0) && sum[REG_WIDTH]) begin
      value_d = '1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/generic_cntr_regs.sv
// Bank of event counters exposed on the register ring; ring fields are registered with 1-clk latency.
module generic_cntr_regs
  import generic_cntr_regs_pkg::*;
#(
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int TAG               = 0,
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int NUM_REGS_USED     = 8,
  parameter int REG_START_ADDR    = 0,
  parameter int INPUT_WIDTH       = 1,
  parameter int REG_WIDTH         = 32,
  parameter int RESET_ON_READ     = 0,
  parameter int SATURATE          = 0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  reg_req_in,
  input  logic                                  reg_ack_in,
  input  logic                                  reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]        reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]       reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]          reg_src_in,
  output logic                                  reg_req_out,
  output logic                                  reg_ack_out,
  output logic                                  reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]        reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]       reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]          reg_src_out,
  input  logic [NUM_REGS_USED*INPUT_WIDTH-1:0]  updates
);

  localparam int          DW = `CPCI_NF2_DATA_WIDTH;
  localparam int          AW = `UDP_REG_ADDR_WIDTH;
  localparam int          TW = AW - REG_ADDR_WIDTH;
  localparam int unsigned LO = REG_START_ADDR;

  logic                          req_q, req_d;
  logic                          ack_q, ack_d;
  logic                          rd_wr_q, rd_wr_d;
  logic [AW-1:0]                 addr_q, addr_d;
  logic [DW-1:0]                 data_q, data_d;
  logic [UDP_REG_SRC_WIDTH-1:0]  src_q, src_d;

  logic [REG_WIDTH-1:0]          cnt_value [NUM_REGS_USED];
  logic [NUM_REGS_USED-1:0]      load_sel;
  logic [NUM_REGS_USED-1:0]      clr_sel;
  logic [REG_WIDTH-1:0]          rd_val;
  logic                          tag_ok;
  logic                          in_range;
  int unsigned                   idx;
  acc_e                          acc;

  // Offset from the start address wraps huge when below it, so one compare covers both bounds.
  always_comb begin
    tag_ok   = (reg_addr_in[AW-1:REG_ADDR_WIDTH] == TW'(TAG));
    idx      = 32'(reg_addr_in[REG_ADDR_WIDTH-1:0]) - LO;
    in_range = (idx < 32'(NUM_REGS_USED));
    acc      = classify(reg_req_in, reg_ack_in, reg_rd_wr_L_in, tag_ok, in_range);
  end

  always_comb begin
    load_sel = '0;
    clr_sel  = '0;
    rd_val   = '0;
    for (int unsigned i = 0; i < NUM_REGS_USED; i++) begin
      if (idx == i) begin
        rd_val      = cnt_value[i];
        load_sel[i] = (acc == ACC_WRITE);
        clr_sel[i]  = (acc == ACC_READ) && (RESET_ON_READ != 0);
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS_USED; g++) begin : g_cell
    generic_cntr_cell #(
      .REG_WIDTH   (REG_WIDTH),
      .INPUT_WIDTH (INPUT_WIDTH),
      .SATURATE    (SATURATE)
    ) u_cell (
      .clk          (clk),
      .reset        (reset),
      .inc          (updates[INPUT_WIDTH*g +: INPUT_WIDTH]),
      .load         (load_sel[g]),
      .load_val     (reg_data_in[REG_WIDTH-1:0]),
      .clear_to_inc (clr_sel[g]),
      .value        (cnt_value[g])
    );
  end

  always_comb begin
    req_d   = reg_req_in;
    ack_d   = reg_ack_in;
    rd_wr_d = reg_rd_wr_L_in;
    addr_d  = reg_addr_in;
    data_d  = reg_data_in;
    src_d   = reg_src_in;
    case (acc)
      ACC_READ: begin
        ack_d  = 1'b1;
        data_d = DW'(rd_val);
      end
      ACC_WRITE: begin
        ack_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q   <= 1'b0;
      ack_q   <= 1'b0;
      rd_wr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      req_q   <= req_d;
      ack_q   <= ack_d;
      rd_wr_q <= rd_wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign reg_req_out     = req_q;
  assign reg_ack_out     = ack_q;
  assign reg_rd_wr_L_out = rd_wr_q;
  assign reg_addr_out    = addr_q;
  assign reg_data_out    = data_q;
  assign reg_src_out     = src_q;

endmodule

// File: tb/tb_generic_cntr_regs.sv
// Directed bench for generic_cntr_regs: four configurations share one register ring input.
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif

module tb_generic_cntr_regs;

  localparam int AW = `UDP_REG_ADDR_WIDTH;
  localparam int DW = `CPCI_NF2_DATA_WIDTH;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_in, ack_in, rdwr_in;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic [1:0]    src_in;

  logic [15:0] upd_a;
  logic [7:0]  upd_w, upd_s, upd_r;

  logic          a_req, a_ack, a_rdwr, w_req, w_ack, w_rdwr, s_req, s_ack, s_rdwr, r_req, r_ack, r_rdwr;
  logic [AW-1:0] a_addr, w_addr, s_addr, r_addr;
  logic [DW-1:0] a_data, w_data, s_data, r_data;
  logic [1:0]    a_src, w_src, s_src, r_src;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  generic_cntr_regs #(.TAG(1), .NUM_REGS_USED(8), .INPUT_WIDTH(2), .REG_WIDTH(32),
                      .RESET_ON_READ(0), .SATURATE(0)) u_a (
    .clk(clk), .reset(reset), .reg_req_in(req_in), .reg_ack_in(ack_in), .reg_rd_wr_L_in(rdwr_in),
    .reg_addr_in(addr_in), .reg_data_in(data_in), .reg_src_in(src_in),
    .reg_req_out(a_req), .reg_ack_out(a_ack), .reg_rd_wr_L_out(a_rdwr), .reg_addr_out(a_addr),
    .reg_data_out(a_data), .reg_src_out(a_src), .updates(upd_a));

  generic_cntr_regs #(.TAG(2), .NUM_REGS_USED(8), .INPUT_WIDTH(1), .REG_WIDTH(8),
                      .RESET_ON_READ(0), .SATURATE(0)) u_w (
    .clk(clk), .reset(reset), .reg_req_in(req_in), .reg_ack_in(ack_in), .reg_rd_wr_L_in(rdwr_in),
    .reg_addr_in(addr_in), .reg_data_in(data_in), .reg_src_in(src_in),
    .reg_req_out(w_req), .reg_ack_out(w_ack), .reg_rd_wr_L_out(w_rdwr), .reg_addr_out(w_addr),
    .reg_data_out(w_data), .reg_src_out(w_src), .updates(upd_w));

  generic_cntr_regs #(.TAG(2), .NUM_REGS_USED(8), .INPUT_WIDTH(1), .REG_WIDTH(8),
                      .RESET_ON_READ(0), .SATURATE(1)) u_s (
    .clk(clk), .reset(reset), .reg_req_in(req_in), .reg_ack_in(ack_in), .reg_rd_wr_L_in(rdwr_in),
    .reg_addr_in(addr_in), .reg_data_in(data_in), .reg_src_in(src_in),
    .reg_req_out(s_req), .reg_ack_out(s_ack), .reg_rd_wr_L_out(s_rdwr), .reg_addr_out(s_addr),
    .reg_data_out(s_data), .reg_src_out(s_src), .updates(upd_s));

  generic_cntr_regs #(.TAG(3), .NUM_REGS_USED(8), .INPUT_WIDTH(1), .REG_WIDTH(32),
                      .RESET_ON_READ(1), .SATURATE(0)) u_r (
    .clk(clk), .reset(reset), .reg_req_in(req_in), .reg_ack_in(ack_in), .reg_rd_wr_L_in(rdwr_in),
    .reg_addr_in(addr_in), .reg_data_in(data_in), .reg_src_in(src_in),
    .reg_req_out(r_req), .reg_ack_out(r_ack), .reg_rd_wr_L_out(r_rdwr), .reg_addr_out(r_addr),
    .reg_data_out(r_data), .reg_src_out(r_src), .updates(upd_r));

  function automatic logic [AW-1:0] mk(input int tag, input int off);
    return AW'(tag * 32 + off);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic req, input logic ack, input logic rdwr,
                       input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [1:0] src);
    req_in  = req;
    ack_in  = ack;
    rdwr_in = rdwr;
    addr_in = addr;
    data_in = data;
    src_in  = src;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b1, '0, '0, 2'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle();
    upd_a = '0; upd_w = '0; upd_s = '0; upd_r = '0;
    #1;
    chk("rst_a_req", 32'(a_req), 32'd0);
    chk("rst_a_ack", 32'(a_ack), 32'd0);
    chk("rst_a_data", a_data, 32'd0);
    chk("rst_r_ack", 32'(r_ack), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Counter 3 of u_a counts 10 single-unit events.
    upd_a = 16'h0040;
    repeat (10) step();
    upd_a = '0;
    chk("pre_read_req", 32'(a_req), 32'd0);
    drive(1'b1, 1'b0, 1'b1, mk(1, 3), 32'd0, 2'd2);
    step();
    chk("inc_ack", 32'(a_ack), 32'd1);
    chk("inc_data", a_data, 32'd10);
    chk("inc_req", 32'(a_req), 32'd1);
    chk("inc_rdwr", 32'(a_rdwr), 32'd1);
    chk("inc_addr", 32'(a_addr), 32'(mk(1, 3)));
    chk("inc_src", 32'(a_src), 32'd2);

    // Pass-through: wrong tag, out of range, already acked.
    drive(1'b1, 1'b0, 1'b1, mk(5, 3), 32'hDEADBEEF, 2'd1);
    step();
    chk("pt_tag_ack", 32'(a_ack), 32'd0);
    chk("pt_tag_data", a_data, 32'hDEADBEEF);
    chk("pt_tag_addr", 32'(a_addr), 32'(mk(5, 3)));
    chk("pt_tag_src", 32'(a_src), 32'd1);
    drive(1'b1, 1'b0, 1'b0, mk(1, 8), 32'h12345678, 2'd3);
    step();
    chk("pt_rng_ack", 32'(a_ack), 32'd0);
    chk("pt_rng_data", a_data, 32'h12345678);
    chk("pt_rng_rdwr", 32'(a_rdwr), 32'd0);
    drive(1'b1, 1'b1, 1'b1, mk(1, 3), 32'hCAFEF00D, 2'd0);
    step();
    chk("pt_ack_ack", 32'(a_ack), 32'd1);
    chk("pt_ack_data", a_data, 32'hCAFEF00D);
    drive(1'b1, 1'b0, 1'b1, mk(1, 3), 32'd0, 2'd0);
    step();
    chk("pt_unchanged", a_data, 32'd10);

    // Write 100 to counter 1 with inc=2; counter 3 keeps counting in the same cycle.
    drive(1'b1, 1'b0, 1'b0, mk(1, 1), 32'd100, 2'd1);
    upd_a = 16'h0048;
    step();
    upd_a = '0;
    chk("wr_ack", 32'(a_ack), 32'd1);
    chk("wr_echo", a_data, 32'd100);
    drive(1'b1, 1'b0, 1'b1, mk(1, 1), 32'd0, 2'd0);
    step();
    chk("wr_readback", a_data, 32'd102);
    drive(1'b1, 1'b0, 1'b1, mk(1, 3), 32'd0, 2'd0);
    step();
    chk("b2b_other_cntr", a_data, 32'd11);
    chk("b2b_ack", 32'(a_ack), 32'd1);
    idle();

    // Wrap versus saturate on 8-bit counters.
    drive(1'b1, 1'b0, 1'b0, mk(2, 0), 32'h000000FE, 2'd0);
    upd_w = 8'h01; upd_s = 8'h01;
    step();
    chk("wrap_wr_echo", w_data, 32'h000000FE);
    chk("sat_wr_ack", 32'(s_ack), 32'd1);
    idle();
    step();
    step();
    upd_w = '0; upd_s = '0;
    drive(1'b1, 1'b0, 1'b1, mk(2, 0), 32'd0, 2'd0);
    step();
    chk("wrap_read", w_data, 32'h00000001);
    chk("sat_read", s_data, 32'h000000FF);
    drive(1'b1, 1'b0, 1'b0, mk(2, 1), 32'h000000FF, 2'd0);
    upd_w = 8'h02; upd_s = 8'h02;
    step();
    upd_w = '0; upd_s = '0;
    drive(1'b1, 1'b0, 1'b1, mk(2, 1), 32'd0, 2'd0);
    step();
    chk("wrap_wr_sum", w_data, 32'h00000000);
    chk("sat_wr_sum", s_data, 32'h000000FF);
    idle();

    // Reset-on-read keeps the same-cycle event.
    drive(1'b1, 1'b0, 1'b0, mk(3, 2), 32'd5, 2'd0);
    step();
    chk("ror_wr_ack", 32'(r_ack), 32'd1);
    drive(1'b1, 1'b0, 1'b1, mk(3, 2), 32'd0, 2'd0);
    upd_r = 8'h04;
    step();
    upd_r = '0;
    chk("ror_first", r_data, 32'd5);
    step();
    chk("ror_second", r_data, 32'd1);
    step();
    chk("ror_third", r_data, 32'd0);
    idle();

    // Reset asserted while a read is presented and acked.
    drive(1'b1, 1'b0, 1'b1, mk(1, 3), 32'd0, 2'd0);
    step();
    chk("mid_pre_ack", 32'(a_ack), 32'd1);
    chk("mid_pre_data", a_data, 32'd11);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_async_ack", 32'(a_ack), 32'd0);
    chk("mid_async_req", 32'(a_req), 32'd0);
    chk("mid_async_data", a_data, 32'd0);
    chk("mid_async_addr", 32'(a_addr), 32'd0);
    step();
    chk("mid_held_ack", 32'(a_ack), 32'd0);
    idle();
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("mid_no_replay_ack", 32'(a_ack), 32'd0);
    chk("mid_no_replay_req", 32'(a_req), 32'd0);
    drive(1'b1, 1'b0, 1'b1, mk(1, 3), 32'd0, 2'd0);
    step();
    chk("mid_cntr3_clr", a_data, 32'd0);
    drive(1'b1, 1'b0, 1'b1, mk(1, 1), 32'd0, 2'd0);
    step();
    chk("mid_cntr1_clr", a_data, 32'd0);
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/generic_cntr_regs.md
GENERIC_CNTR_REGS -- requirements
Module: generic_cntr_regs

Interface
REQ-001 SHALL have parameter UDP_REG_SRC_WIDTH, default 2, width of the request-source field.
REQ-002 SHALL have parameter TAG, default 0, block tag matched against the upper address bits.
REQ-003 SHALL have parameter REG_ADDR_WIDTH, default 5, width of the in-block address.
REQ-004 SHALL have parameter NUM_REGS_USED, default 8, number of counters (1..2^REG_ADDR_WIDTH).
REQ-005 SHALL have parameter REG_START_ADDR, default 0, in-block address of counter 0.
REQ-006 SHALL have parameter INPUT_WIDTH, default 1, width of each per-counter increment.
REQ-007 SHALL have parameter REG_WIDTH, default 32, counter width (INPUT_WIDTH..`CPCI_NF2_DATA_WIDTH).
REQ-008 SHALL have parameter RESET_ON_READ, default 0, which clears a counter when it is read.
REQ-009 SHALL have parameter SATURATE, default 0, which selects hold-at-max (1) or wrap (0).
REQ-010 SHALL have the port list: clk  in  1  sole clock, rising edge.
REQ-011 SHALL have the port list: reset  in  1  asynchronous, active-low reset.
REQ-012 SHALL have reg_req_in/reg_ack_in/reg_rd_wr_L_in  in  1 each  register-ring request, ack and read(1)/write(0).
REQ-013 SHALL have reg_addr_in  in  `UDP_REG_ADDR_WIDTH; reg_data_in  in  `CPCI_NF2_DATA_WIDTH; reg_src_in  in  UDP_REG_SRC_WIDTH.
REQ-014 SHALL have reg_*_out, same six fields as outputs, all registered.
REQ-015 SHALL have updates  in  NUM_REGS_USED*INPUT_WIDTH  per-counter increments; counter i uses bits [INPUT_WIDTH*(i+1)-1 : INPUT_WIDTH*i].

Function
REQ-016 SHALL register every ring output one cycle after its input, for a fixed latency of 1 clk.
REQ-017 SHALL define a hit as reg_req_in=1, reg_ack_in=0, addr[`UDP_REG_ADDR_WIDTH-1:REG_ADDR_WIDTH]==TAG, and REG_START_ADDR <= addr[REG_ADDR_WIDTH-1:0] < REG_START_ADDR+NUM_REGS_USED.
REQ-018 SHALL pass all fields through unchanged on a non-hit, including a request whose reg_ack_in is already 1.
REQ-019 SHALL, on a read hit, set ack_out=1 and data_out to the counter value before this cycle's update, zero-extended to 32 bits.
REQ-020 SHALL, on a write hit, set ack_out=1, echo data_out=reg_data_in, and set the counter to reg_data_in[REG_WIDTH-1:0] plus the same-cycle increment.
REQ-021 SHALL, on a read hit with RESET_ON_READ=1, make the counter's next value equal that cycle's increment so no event is lost.
REQ-022 SHALL, each cycle without a hit, set counter i to counter i plus updates_i, computed at REG_WIDTH+1 bits.
REQ-023 SHALL, when SATURATE=0, discard the carry so the counter wraps modulo 2^REG_WIDTH.
REQ-024 SHALL, when SATURATE=1, hold the counter at 2^REG_WIDTH-1 on overflow, and apply saturation also to the write+increment sum.
REQ-025 SHALL let a hit affect only the addressed counter; all other counters update normally that cycle.
REQ-026 SHALL accept back-to-back hits, one per cycle, with no stall.

Reset
REQ-027 SHALL, while reset=0, asynchronously clear every counter and every reg_*_out to 0.
REQ-028 SHALL drop a request in flight at reset assertion; it is not replayed.
REQ-029 SHALL ignore updates and ring input on the first rising clk after deassertion only if reset was still low at that edge.

Structure
REQ-030 SHALL take `CPCI_NF2_DATA_WIDTH and `UDP_REG_ADDR_WIDTH from the shared defines include, and SHALL define no new global constants.
REQ-031 SHALL implement each counter as sub-module generic_cntr_cell (REG_WIDTH, INPUT_WIDTH, SATURATE), with inputs inc, load, load_val and clear_to_inc and output value, instantiated in a generate loop.

Verification
REQ-032 SHALL cover increments: NUM=8, INPUT_WIDTH=1, updates bit 3 high for 10 cycles, then read addr 3 -> ack_out=1, data_out=10, latency 1 clk.
REQ-033 SHALL cover wrap: REG_WIDTH=8, SATURATE=0, write 0xFE to counter 0 with inc=1 for 3 cycles -> read 0x01; with SATURATE=1 -> read 0xFF.
REQ-034 SHALL cover reset-on-read: RESET_ON_READ=1, counter 2=5, read with same-cycle inc=1 -> data_out=5, next read (no inc) returns 1.
REQ-035 SHALL cover pass-through: wrong TAG, out-of-range addr 8, or reg_ack_in=1 -> outputs equal inputs delayed 1 clk, counters unchanged.
REQ-036 SHALL cover write with increment: write 100 to counter 1 with inc=2 the same cycle -> next read returns 102, data_out on write=100.
REQ-037 SHALL cover reset mid-operation: assert reset low during a read -> all outputs 0 asynchronously, counters 0, no ack after release.
